// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one gen_alu datapath between four requesters.
// Also holds the ripple-carry ALU (gen_alu built from alu_slice bit cells).

module alu_slice (
    input  logic       a,
    input  logic       b,
    input  logic       ci,
    input  logic [1:0] f,
    output logic       s,
    output logic       co
);
    logic w_bSel;

    // f[0] inverts b so that subtract is a + ~b + carry-in of 1
    assign w_bSel = b ^ f[0];
    assign s      = f[1] ? (f[0] ? (a | b) : (a & b)) : (a ^ w_bSel ^ ci);
    assign co     = f[1] ? 1'b0 : ((a & w_bSel) | (ci & (a ^ w_bSel)));
endmodule

module gen_alu #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   f,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] w_c;

    assign w_c[0] = (f == 2'b01);
    assign co     = w_c[N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        alu_slice u_slice (
            .a (a[i]),
            .b (b[i]),
            .ci(w_c[i]),
            .f (f),
            .s (s[i]),
            .co(w_c[i+1])
        );
    end
endmodule

module alu_arbiter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     req,
    input  logic [4*N-1:0] a_bus,
    input  logic [4*N-1:0] b_bus,
    input  logic [7:0]     f_bus,
    output logic [3:0]     gnt,
    output logic [3:0]     done,
    output logic [N-1:0]   result,
    output logic           co,
    output logic           busy,
    output logic [15:0]    op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t       r_state;
    logic [1:0]   r_ptr;
    logic [1:0]   r_id;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [1:0]   r_f;
    logic [3:0]   r_gnt;
    logic [3:0]   r_done;
    logic [N-1:0] r_result;
    logic         r_co;
    logic         r_busy;
    logic [15:0]  r_opCount;

    logic [1:0]   w_base;
    logic [1:0]   w_idx;
    logic [1:0]   w_win;
    logic         w_any;
    logic [N-1:0] w_aluS;
    logic         w_aluCo;

    gen_alu #(.N(N)) u_alu (
        .a (r_a),
        .b (r_b),
        .f (r_f),
        .s (w_aluS),
        .co(w_aluCo)
    );

    // In DONE the pointer update and the next arbitration share one edge,
    // so arbitrate from the pointer value that is about to be written.
    assign w_base = (r_state == DONE) ? (r_id + 2'd1) : r_ptr;
    assign w_any  = |req;

    always_comb begin
        w_win = w_base;
        w_idx = w_base;
        for (int k = 3; k >= 0; k--) begin
            w_idx = w_base + k[1:0];
            if (req[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ptr     <= 2'd0;
            r_id      <= 2'd0;
            r_a       <= '0;
            r_b       <= '0;
            r_f       <= 2'b00;
            r_gnt     <= 4'b0000;
            r_done    <= 4'b0000;
            r_result  <= '0;
            r_co      <= 1'b0;
            r_busy    <= 1'b0;
            r_opCount <= 16'h0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a     <= a_bus[w_win*N +: N];
                        r_b     <= b_bus[w_win*N +: N];
                        r_f     <= f_bus[2*w_win +: 2];
                        r_id    <= w_win;
                        r_gnt   <= 4'b0001 << w_win;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_result <= w_aluS;
                    r_co     <= w_aluCo;
                    r_gnt    <= 4'b0000;
                    r_done   <= 4'b0001 << r_id;
                    r_state  <= DONE;
                end
                DONE: begin
                    r_done <= 4'b0000;
                    r_ptr  <= r_id + 2'd1;
                    if (r_opCount != 16'hFFFF) begin
                        r_opCount <= r_opCount + 16'd1;
                    end
                    if (w_any) begin
                        r_a     <= a_bus[w_win*N +: N];
                        r_b     <= b_bus[w_win*N +: N];
                        r_f     <= f_bus[2*w_win +: 2];
                        r_id    <= w_win;
                        r_gnt   <= 4'b0001 << w_win;
                        r_state <= EXEC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign result   = r_result;
    assign co       = r_co;
    assign busy     = r_busy;
    assign op_count = r_opCount;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; one task per scenario,
// outputs sampled on the falling edge, inputs driven on the falling edge.

module tb_alu_arbiter;
    localparam int N = 8;

    logic           clk;
    logic           reset;
    logic [3:0]     req;
    logic [4*N-1:0] a_bus;
    logic [4*N-1:0] b_bus;
    logic [7:0]     f_bus;
    logic [3:0]     gnt;
    logic [3:0]     done;
    logic [N-1:0]   result;
    logic           co;
    logic           busy;
    logic [15:0]    op_count;

    int passCount;
    int checkCount;

    alu_arbiter #(.N(N)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .a_bus   (a_bus),
        .b_bus   (b_bus),
        .f_bus   (f_bus),
        .gnt     (gnt),
        .done    (done),
        .result  (result),
        .co      (co),
        .busy    (busy),
        .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setOperands(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        a_bus[i*N +: N] = a;
        b_bus[i*N +: N] = b;
        f_bus[2*i +: 2] = f;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req   = 4'b0000;
        a_bus = '0;
        b_bus = '0;
        f_bus = '0;
        #2;
        checkCount++; if (gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b expected 0000", gnt); else passCount++;
        checkCount++; if (done !== 4'b0000) $display("[TB] FAIL reset_done: got %b expected 0000", done); else passCount++;
        checkCount++; if (result !== 8'd0) $display("[TB] FAIL reset_result: got %0d expected 0", result); else passCount++;
        checkCount++; if (co !== 1'b0) $display("[TB] FAIL reset_co: got %b expected 0", co); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (op_count !== 16'd0) $display("[TB] FAIL reset_op_count: got %0d expected 0", op_count); else passCount++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_add;
        setOperands(0, 8'd200, 8'd100, 2'b00);
        req = 4'b0001;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b0001) $display("[TB] FAIL add_gnt: got %b expected 0001", gnt); else passCount++;
        checkCount++; if (done !== 4'b0000) $display("[TB] FAIL add_done_early: got %b expected 0000", done); else passCount++;
        req = 4'b0000;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b0000) $display("[TB] FAIL add_gnt_drop: got %b expected 0000", gnt); else passCount++;
        checkCount++; if (done !== 4'b0001) $display("[TB] FAIL add_done: got %b expected 0001", done); else passCount++;
        checkCount++; if (result !== 8'd44) $display("[TB] FAIL add_result: got %0d expected 44", result); else passCount++;
        checkCount++; if (co !== 1'b1) $display("[TB] FAIL add_co: got %b expected 1", co); else passCount++;
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL add_busy: got %b expected 1", busy); else passCount++;
        @(negedge clk);
        checkCount++; if (done !== 4'b0000) $display("[TB] FAIL add_done_pulse: got %b expected 0000", done); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL add_idle_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (op_count !== 16'd1) $display("[TB] FAIL add_op_count: got %0d expected 1", op_count); else passCount++;
    endtask

    task automatic test_subtract;
        setOperands(2, 8'd5, 8'd3, 2'b01);
        req = 4'b0100;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b0100) $display("[TB] FAIL sub_pos_gnt: got %b expected 0100", gnt); else passCount++;
        req = 4'b0000;
        @(negedge clk);
        checkCount++; if (done !== 4'b0100) $display("[TB] FAIL sub_pos_done: got %b expected 0100", done); else passCount++;
        checkCount++; if (result !== 8'd2) $display("[TB] FAIL sub_pos_result: got %0d expected 2", result); else passCount++;
        checkCount++; if (co !== 1'b1) $display("[TB] FAIL sub_pos_co: got %b expected 1", co); else passCount++;
        @(negedge clk);
        setOperands(2, 8'd3, 8'd5, 2'b01);
        req = 4'b0100;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b0100) $display("[TB] FAIL sub_neg_gnt: got %b expected 0100", gnt); else passCount++;
        req = 4'b0000;
        @(negedge clk);
        checkCount++; if (done !== 4'b0100) $display("[TB] FAIL sub_neg_done: got %b expected 0100", done); else passCount++;
        checkCount++; if (result !== 8'd254) $display("[TB] FAIL sub_neg_result: got %0d expected 254", result); else passCount++;
        checkCount++; if (co !== 1'b0) $display("[TB] FAIL sub_neg_co: got %b expected 0", co); else passCount++;
        @(negedge clk);
        checkCount++; if (op_count !== 16'd3) $display("[TB] FAIL sub_op_count: got %0d expected 3", op_count); else passCount++;
    endtask

    // Pointer sits at 3 here, so requester 3 wins before reset and 0 after.
    task automatic test_reset_mid_op;
        setOperands(3, 8'd1, 8'd1, 2'b00);
        setOperands(0, 8'd10, 8'd20, 2'b00);
        req = 4'b1001;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b1000) $display("[TB] FAIL rst_pre_gnt: got %b expected 1000", gnt); else passCount++;
        #1;
        reset = 1'b1;
        req   = 4'b0000;
        #1;
        checkCount++; if (gnt !== 4'b0000) $display("[TB] FAIL rst_gnt: got %b expected 0000", gnt); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (result !== 8'd0) $display("[TB] FAIL rst_result: got %0d expected 0", result); else passCount++;
        checkCount++; if (op_count !== 16'd0) $display("[TB] FAIL rst_op_count: got %0d expected 0", op_count); else passCount++;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            checkCount++; if (done !== 4'b0000) $display("[TB] FAIL rst_no_done: got %b expected 0000", done); else passCount++;
        end
        reset = 1'b0;
        req   = 4'b1001;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b0001) $display("[TB] FAIL rst_ptr0_gnt: got %b expected 0001", gnt); else passCount++;
        req = 4'b0000;
        @(negedge clk);
        checkCount++; if (done !== 4'b0001) $display("[TB] FAIL rst_after_done: got %b expected 0001", done); else passCount++;
        checkCount++; if (result !== 8'd30) $display("[TB] FAIL rst_after_result: got %0d expected 30", result); else passCount++;
        @(negedge clk);
        checkCount++; if (op_count !== 16'd1) $display("[TB] FAIL rst_after_op_count: got %0d expected 1", op_count); else passCount++;
    endtask

    task automatic test_pointer_wrap;
        setOperands(3, 8'd100, 8'd27, 2'b00);
        req = 4'b1000;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b1000) $display("[TB] FAIL wrap_serve3_gnt: got %b expected 1000", gnt); else passCount++;
        req = 4'b0000;
        @(negedge clk);
        checkCount++; if (result !== 8'd127) $display("[TB] FAIL wrap_serve3_result: got %0d expected 127", result); else passCount++;
        @(negedge clk);
        setOperands(0, 8'd255, 8'd1, 2'b00);
        setOperands(3, 8'd7, 8'd9, 2'b01);
        req = 4'b1001;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b0001) $display("[TB] FAIL wrap_first_gnt: got %b expected 0001", gnt); else passCount++;
        req = 4'b1000;
        @(negedge clk);
        checkCount++; if (done !== 4'b0001) $display("[TB] FAIL wrap_first_done: got %b expected 0001", done); else passCount++;
        checkCount++; if (result !== 8'd0) $display("[TB] FAIL wrap_first_result: got %0d expected 0", result); else passCount++;
        checkCount++; if (co !== 1'b1) $display("[TB] FAIL wrap_first_co: got %b expected 1", co); else passCount++;
        @(negedge clk);
        checkCount++; if (gnt !== 4'b1000) $display("[TB] FAIL wrap_second_gnt: got %b expected 1000", gnt); else passCount++;
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL wrap_second_busy: got %b expected 1", busy); else passCount++;
        req = 4'b0000;
        @(negedge clk);
        checkCount++; if (done !== 4'b1000) $display("[TB] FAIL wrap_second_done: got %b expected 1000", done); else passCount++;
        checkCount++; if (result !== 8'd254) $display("[TB] FAIL wrap_second_result: got %0d expected 254", result); else passCount++;
        checkCount++; if (co !== 1'b0) $display("[TB] FAIL wrap_second_co: got %b expected 0", co); else passCount++;
        @(negedge clk);
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL wrap_idle_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (op_count !== 16'd4) $display("[TB] FAIL wrap_op_count: got %0d expected 4", op_count); else passCount++;
    endtask

    task automatic test_back_to_back;
        logic [3:0] expOneHot;
        logic [7:0] expResult;
        int         expId;
        for (int i = 0; i < 4; i++) begin
            setOperands(i, 8'(i * 10 + 1), 8'(i), 2'b00);
        end
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            expId     = k % 4;
            expOneHot = 4'b0001 << expId;
            expResult = 8'(11 * expId + 1);
            @(negedge clk);
            checkCount++; if (gnt !== expOneHot) $display("[TB] FAIL rr_gnt[%0d]: got %b expected %b", k, gnt, expOneHot); else passCount++;
            checkCount++; if (busy !== 1'b1) $display("[TB] FAIL rr_busy_exec[%0d]: got %b expected 1", k, busy); else passCount++;
            req[expId] = 1'b0;
            @(negedge clk);
            checkCount++; if (done !== expOneHot) $display("[TB] FAIL rr_done[%0d]: got %b expected %b", k, done, expOneHot); else passCount++;
            checkCount++; if (result !== expResult) $display("[TB] FAIL rr_result[%0d]: got %0d expected %0d", k, result, expResult); else passCount++;
            checkCount++; if (busy !== 1'b1) $display("[TB] FAIL rr_busy_done[%0d]: got %b expected 1", k, busy); else passCount++;
            if (k < 7) req[expId] = 1'b1;
            else req = 4'b0000;
        end
        @(negedge clk);
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rr_idle_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (op_count !== 16'd12) $display("[TB] FAIL rr_op_count: got %0d expected 12", op_count); else passCount++;
    endtask

    task automatic test_saturation;
        force dut.r_opCount = 16'hFFFE;
        #1;
        release dut.r_opCount;
        #1;
        checkCount++; if (op_count !== 16'hFFFE) $display("[TB] FAIL sat_preload: got %h expected fffe", op_count); else passCount++;
        @(negedge clk);
        setOperands(1, 8'd1, 8'd2, 2'b00);
        for (int j = 0; j < 3; j++) begin
            req = 4'b0010;
            @(negedge clk);
            req = 4'b0000;
            @(negedge clk);
            @(negedge clk);
            checkCount++; if (op_count !== 16'hFFFF) $display("[TB] FAIL sat_op_count[%0d]: got %h expected ffff", j, op_count); else passCount++;
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        test_reset();
        test_single_add();
        test_subtract();
        test_reset_mid_op();
        test_pointer_wrap();
        test_back_to_back();
        test_saturation();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `gen_alu` datapath between four requesters. Requests are granted round-robin, and each winner's operands and function code are latched into the ALU. The result and carry are registered, and completion is signalled to the winner with a one-cycle `done` pulse. It sits between the lab's requester blocks and the single `gen_alu` instance, which it instantiates internally.

## Interface
- `N`, default 8: ALU operand and result width, passed to the internal `gen_alu`.
- Requester count is fixed at 4. Requester `i` uses slice `[i*N +: N]` of `a_bus`/`b_bus` and `[2*i +: 2]` of `f_bus`.

Ports:
- `clk`  in  1  the block's single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  4  request per requester. The requester holds it high, with stable operands, until it sees `gnt`.
- `a_bus`  in  4*N  A operands, one per requester.
- `b_bus`  in  4*N  B operands, one per requester.
- `f_bus`  in  8  2-bit function codes, one per requester.
- `gnt`  out  4  one-hot; the winner's operands have been latched.
- `done`  out  4  one-hot, 1-cycle pulse; `result` and `co` are valid for that requester.
- `result`  out  N  registered ALU sum `s`; held until the next completion.
- `co`  out  1  registered ALU carry-out; held like `result`.
- `busy`  out  1  high while in EXEC or DONE.
- `op_count`  out  16  completed operations; saturates at 16'hFFFF.

## Operation
- The FSM has three states: IDLE, EXEC and DONE. All outputs are registered or decoded from registered state (Moore outputs).
- **IDLE:**
  - If `req` is non-zero, pick the first requesting index starting at priority pointer `ptr` and going upward modulo 4.
  - Latch that requester's a/b/f into the operand registers, store the winner id, and go to EXEC.
  - Otherwise stay in IDLE.
- **EXEC:**
  - `gnt[id]` = 1.
  - The `gen_alu` evaluates the operand registers combinationally; `f` is passed unmodified.
  - At the clock edge, capture `s` into `result` and `c[N]` into `co`, then go to DONE.
- **DONE:**
  - `done[id]` = 1.
  - At the clock edge, set `ptr` to `(id+1) mod 4` and increment `op_count` unless it is saturated.
  - Arbitrate in the same cycle using the new pointer value `(id+1) mod 4`. If any `req` is high, latch the winner and go to EXEC (back-to-back operation); otherwise go to IDLE.
- Function codes: `2'b00` is a+b with `c[0]`=0; `2'b01` is a−b, computed as a+~b+1 with `c[0]`=1. Codes `2'b1x` behave as defined by `alu_slice`; the arbiter does not interpret `f`.
- Width rules:
  - `result` is the N-bit sum truncated modulo 2^N.
  - For add, `co` is the unsigned carry.
  - For subtract, `co`=1 means no borrow (a ≥ b unsigned).
- Requester rule: drop `req` no later than the first clock edge after `gnt` rises. A `req` still high at the DONE-exit edge counts as a new request and will be served again if it wins.
- `req` bits that go high while the block is in EXEC are not seen until the next arbitration point (the DONE or IDLE edge).
- Operand changes after latching have no effect on the operation in flight.

## Timing
- Reset (asynchronous, immediate) sets:
  - state = IDLE, `ptr` = 0, operand registers = 0
  - `gnt` = 0, `done` = 0, `result` = 0, `co` = 0, `busy` = 0, `op_count` = 0
- An in-flight operation is discarded on reset and produces no `done`. After reset deasserts, the first arbitration happens at the first rising edge that occurs while in IDLE.
- Latency: with `req` sampled at edge k in IDLE, `gnt` is high during cycle k→k+1 and `done` plus the new `result` are visible during cycle k+1→k+2.
- Throughput: with back-to-back requests, one completion every 2 cycles; `busy` stays high throughout.
- Simultaneous requests: exactly one is granted, and the one-hot property holds for both `gnt` and `done`.
- Fairness: a continuously requesting requester waits at most 3 other operations (6 cycles).
- `op_count` at 16'hFFFF stays at 16'hFFFF.

## Test plan
- **Single add:** N=8, req=4'b0001, a0=200, b0=100, f0=00.
  - Required: `gnt`=0001 for 1 cycle, then `done`=0001 with `result`=44 (0x2C) and `co`=1, two cycles after the sampling edge.
- **Subtract both signs:** requester 2 runs 5−3, then 3−5 (f=01).
  - Required: `result`=2 with `co`=1, then `result`=254 with `co`=0. `done`=0100 each time.
- **Round-robin:** `req`=1111 held, each requester dropping its request after `gnt`, then re-raising it after its `done`.
  - Required grant order is 0,1,2,3,0,1,… with a `done` every 2 cycles and `busy` continuously high.
- **Pointer wrap:** serve requester 3, then raise `req`=1001.
  - Required: requester 0 wins first, then requester 3.
- **Reset mid-op:** assert `reset` during EXEC.
  - Required: all outputs are 0 immediately, no `done` pulse occurs, and the next request is served from `ptr`=0.
- **Counter saturation:** force `op_count` to 16'hFFFE, then complete 3 operations.
  - Required: `op_count` reads 16'hFFFF and stays there.
